// File: rtl/pipe_add_sub_acc.sv
// Pipelined pre-adder / post-adder / accumulator for the DSP datapath.
// The optional input register stage is followed by the output stage that holds P.
// Z selects the external z, the block's own result (accumulate) or zero.
module pipe_add_sub_acc #(
  parameter int WIDTH     = 48,
  parameter int PRE_WIDTH = 18,
  parameter int IN_REG    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [PRE_WIDTH-1:0] d,
  input  logic [PRE_WIDTH-1:0] b,
  input  logic                 pre_op,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     z,
  input  logic [1:0]           zsel,
  input  logic                 post_op,
  input  logic                 carryin,
  input  logic                 acc_clr,
  output logic [PRE_WIDTH-1:0] pre_out,
  output logic [WIDTH-1:0]     out,
  output logic                 carryout,
  output logic                 overflow,
  output logic                 ovf_sticky,
  output logic                 out_valid
);

  // Operands as seen by the output stage.
  logic [PRE_WIDTH-1:0] s1_d, s1_b;
  logic                 s1_pre_op, s1_post_op, s1_cin, s1_vld;
  logic [WIDTH-1:0]     s1_x, s1_z;
  logic [1:0]           s1_zsel;

  if (IN_REG != 0) begin : g_in_reg
    logic [PRE_WIDTH-1:0] d_q, b_q;
    logic                 pre_op_q, post_op_q, cin_q, vld_q;
    logic [WIDTH-1:0]     x_q, z_q;
    logic [1:0]           zsel_q;

    // Stage 1: capture every input each enabled cycle, valid or not.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q       <= '0;
        b_q       <= '0;
        pre_op_q  <= 1'b0;
        x_q       <= '0;
        z_q       <= '0;
        zsel_q    <= 2'b00;
        post_op_q <= 1'b0;
        cin_q     <= 1'b0;
        vld_q     <= 1'b0;
      end else if (ce) begin
        d_q       <= d;
        b_q       <= b;
        pre_op_q  <= pre_op;
        x_q       <= x;
        z_q       <= z;
        zsel_q    <= zsel;
        post_op_q <= post_op;
        cin_q     <= carryin;
        vld_q     <= in_valid;
      end
    end

    assign s1_d       = d_q;
    assign s1_b       = b_q;
    assign s1_pre_op  = pre_op_q;
    assign s1_x       = x_q;
    assign s1_z       = z_q;
    assign s1_zsel    = zsel_q;
    assign s1_post_op = post_op_q;
    assign s1_cin     = cin_q;
    assign s1_vld     = vld_q;
  end else begin : g_no_reg
    assign s1_d       = d;
    assign s1_b       = b;
    assign s1_pre_op  = pre_op;
    assign s1_x       = x;
    assign s1_z       = z;
    assign s1_zsel    = zsel;
    assign s1_post_op = post_op;
    assign s1_cin     = carryin;
    assign s1_vld     = in_valid;
  end

  // Output stage registers.
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 co_q, co_d, ovf_q, ovf_d, stk_q, stk_d, vld_q, vld_d;

  logic [PRE_WIDTH-1:0] pre_sum;
  logic [WIDTH-1:0]     zop;
  logic [WIDTH:0]       r;
  logic                 ovf_now;

  // Arithmetic: pre-adder, Z mux, unsigned WIDTH+1 post-adder and signed overflow.
  always_comb begin
    pre_sum = s1_pre_op ? (s1_d - s1_b) : (s1_d + s1_b);
    case (s1_zsel)
      2'b00:   zop = s1_z;
      2'b01:   zop = out_q;
      default: zop = '0;
    endcase
    if (s1_post_op)
      r = {1'b0, zop} - {1'b0, s1_x} - {{WIDTH{1'b0}}, s1_cin};
    else
      r = {1'b0, zop} + {1'b0, s1_x} + {{WIDTH{1'b0}}, s1_cin};
    // Bit WIDTH of the sign-extended result is zop[msb]^x[msb]^carry/borrow
    // into bit WIDTH, and that carry/borrow is r[WIDTH]. The result fits in
    // WIDTH signed bits exactly when that bit matches r[WIDTH-1].
    ovf_now = zop[WIDTH-1] ^ s1_x[WIDTH-1] ^ r[WIDTH] ^ r[WIDTH-1];
  end

  // Output stage next state: clear beats a valid item, bubbles hold everything.
  always_comb begin
    pre_d = pre_q;
    out_d = out_q;
    co_d  = co_q;
    ovf_d = ovf_q;
    stk_d = stk_q;
    vld_d = 1'b0;
    if (acc_clr) begin
      out_d = '0;
      co_d  = 1'b0;
      ovf_d = 1'b0;
      stk_d = 1'b0;
    end else if (s1_vld) begin
      pre_d = pre_sum;
      out_d = r[WIDTH-1:0];
      co_d  = r[WIDTH];
      ovf_d = ovf_now;
      stk_d = stk_q | ovf_now;
      vld_d = 1'b1;
    end
  end

  // Output stage state register, frozen while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      out_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
      stk_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (ce) begin
      pre_q <= pre_d;
      out_q <= out_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
      stk_q <= stk_d;
      vld_q <= vld_d;
    end
  end

  assign pre_out    = pre_q;
  assign out        = out_q;
  assign carryout   = co_q;
  assign overflow   = ovf_q;
  assign ovf_sticky = stk_q;
  assign out_valid  = vld_q;

endmodule

// File: tb/tb_pipe_add_sub_acc.sv
// Scoreboard bench: dut 0 has IN_REG=1, dut 1 has IN_REG=0. Stimulus pushes
// hand-computed results; a negedge monitor pops on out_valid and checks that
// outputs hold (or are cleared) on cycles without a fresh result.
module tb_pipe_add_sub_acc;
  localparam int W = 48;
  localparam int P = 18;

  logic         clk, rst_n, ce, va, vb, clr_a, clr_b;
  logic [P-1:0] d, b;
  logic         pre_op, post_op, cin;
  logic [W-1:0] x, z;
  logic [1:0]   zsel;

  logic [P-1:0] pre_w [2];
  logic [W-1:0] out_w [2];
  logic         co_w [2], ovf_w [2], stk_w [2], vld_w [2];

  pipe_add_sub_acc #(.WIDTH(W), .PRE_WIDTH(P), .IN_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(va), .d(d), .b(b), .pre_op(pre_op),
    .x(x), .z(z), .zsel(zsel), .post_op(post_op), .carryin(cin), .acc_clr(clr_a),
    .pre_out(pre_w[0]), .out(out_w[0]), .carryout(co_w[0]), .overflow(ovf_w[0]),
    .ovf_sticky(stk_w[0]), .out_valid(vld_w[0]));

  pipe_add_sub_acc #(.WIDTH(W), .PRE_WIDTH(P), .IN_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(vb), .d(d), .b(b), .pre_op(pre_op),
    .x(x), .z(z), .zsel(zsel), .post_op(post_op), .carryin(cin), .acc_clr(clr_b),
    .pre_out(pre_w[1]), .out(out_w[1]), .carryout(co_w[1]), .overflow(ovf_w[1]),
    .ovf_sticky(stk_w[1]), .out_valid(vld_w[1]));

  typedef struct {
    logic [W-1:0] out;
    logic [P-1:0] pre;
    logic         co, ovf, stk;
    int           stamp;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t hold [2];
  int   checks = 0, failures = 0, ecyc = 0;
  logic fresh = 1'b0;
  logic clr_s [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record what the last edge did: enabled or not, clear or not.
  always @(posedge clk) begin
    fresh    = ce && rst_n;
    clr_s[0] = ce && rst_n && clr_a;
    clr_s[1] = ce && rst_n && clr_b;
    if (ce) ecyc++;
  end

  task automatic mon(input int i);
    exp_t e;
    int   lat;
    logic empty;
    lat = (i == 0) ? 2 : 1;
    if (!rst_n) begin
      hold[i].out = '0; hold[i].pre = '0; hold[i].co = 0; hold[i].ovf = 0; hold[i].stk = 0;
      if (i == 0) q0.delete(); else q1.delete();
      return;
    end
    if (!fresh) return;
    if (clr_s[i]) begin
      hold[i].out = '0; hold[i].co = 0; hold[i].ovf = 0; hold[i].stk = 0;
    end
    checks++;
    if (vld_w[i]) begin
      empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        failures++;
        $display("FAIL unexpected dut%0d: out_valid=1 out=%h with nothing expected", i, out_w[i]);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        if (out_w[i] !== e.out || pre_w[i] !== e.pre || co_w[i] !== e.co ||
            ovf_w[i] !== e.ovf || stk_w[i] !== e.stk || (ecyc - e.stamp) != lat) begin
          failures++;
          $display("FAIL result dut%0d: out=%h pre=%h co=%b ovf=%b stk=%b lat=%0d, expected out=%h pre=%h co=%b ovf=%b stk=%b lat=%0d",
                   i, out_w[i], pre_w[i], co_w[i], ovf_w[i], stk_w[i], ecyc - e.stamp,
                   e.out, e.pre, e.co, e.ovf, e.stk, lat);
        end
        hold[i] = e;
      end
    end else begin
      if (out_w[i] !== hold[i].out || pre_w[i] !== hold[i].pre || co_w[i] !== hold[i].co ||
          ovf_w[i] !== hold[i].ovf || stk_w[i] !== hold[i].stk) begin
        failures++;
        $display("FAIL hold dut%0d: out=%h pre=%h co=%b ovf=%b stk=%b, expected out=%h pre=%h co=%b ovf=%b stk=%b",
                 i, out_w[i], pre_w[i], co_w[i], ovf_w[i], stk_w[i],
                 hold[i].out, hold[i].pre, hold[i].co, hold[i].ovf, hold[i].stk);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [P-1:0] dd, bb, input logic po, input logic [W-1:0] xx, zz,
                        input logic [1:0] zs, input logic op, ci);
    d = dd; b = bb; pre_op = po; x = xx; z = zz; zsel = zs; post_op = op; cin = ci;
  endtask

  task automatic push(input int dut, input logic [W-1:0] eo, input logic [P-1:0] ep,
                      input logic eco, eovf, estk);
    exp_t e;
    e.out = eo; e.pre = ep; e.co = eco; e.ovf = eovf; e.stk = estk; e.stamp = ecyc;
    if (dut == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Issue one valid item to a dut with its expected result, then advance a cycle.
  task automatic issue(input int dut, input logic [P-1:0] dd, bb, input logic po,
                       input logic [W-1:0] xx, zz, input logic [1:0] zs, input logic op, ci,
                       input logic [W-1:0] eo, input logic [P-1:0] ep, input logic eco, eovf, estk);
    set_in(dd, bb, po, xx, zz, zs, op, ci);
    va = (dut == 0);
    vb = (dut == 1);
    push(dut, eo, ep, eco, eovf, estk);
    cyc();
  endtask

  task automatic idle(input int n);
    va = 0; vb = 0;
    set_in(0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (n) cyc();
  endtask

  initial begin
    rst_n = 0; ce = 1; va = 0; vb = 0; clr_a = 0; clr_b = 0;
    set_in(0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_out%0d", i), 64'(out_w[i]), 64'h0);
      chk($sformatf("reset_vld%0d", i), 64'(vld_w[i]), 64'h0);
      chk($sformatf("reset_stk%0d", i), 64'(stk_w[i]), 64'h0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    cyc();

    // Basic add/sub and pre-adder wrap
    issue(0, 18'h3FFFF, 1, 0, 30, 100, 2'b00, 0, 1, 131, 0, 0, 0, 0);
    issue(0, 0, 1, 1, 30, 100, 2'b00, 1, 1, 69, 18'h3FFFF, 0, 0, 0);
    issue(0, 5, 3, 0, 10, 5, 2'b00, 1, 0, 48'hFFFF_FFFF_FFFB, 8, 1, 0, 0);
    issue(0, 3, 5, 1, 0, 0, 2'b00, 1, 1, 48'hFFFF_FFFF_FFFF, 18'h3FFFE, 1, 0, 0);
    issue(0, 0, 0, 0, 5, 999, 2'b10, 0, 0, 5, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 6, 999, 2'b11, 1, 0, 48'hFFFF_FFFF_FFFA, 0, 1, 0, 0);
    // Overflow, sticky, carry without overflow
    issue(0, 0, 0, 0, 1, 48'h7FFF_FFFF_FFFF, 2'b00, 0, 0, 48'h8000_0000_0000, 0, 0, 1, 1);
    issue(0, 0, 0, 0, 2, 0, 2'b00, 0, 0, 2, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 1, 48'h8000_0000_0000, 2'b00, 1, 0, 48'h7FFF_FFFF_FFFF, 0, 0, 1, 1);
    issue(0, 0, 0, 0, 3, 10, 2'b00, 0, 0, 13, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 1, 48'hFFFF_FFFF_FFFF, 2'b00, 0, 0, 0, 0, 1, 0, 1);
    idle(3);

    // Clear drops the item reaching the output stage; the item behind it starts the accumulation
    set_in(1, 1, 0, 1, 500, 2'b00, 0, 0);
    va = 1;
    cyc();
    clr_a = 1;
    issue(0, 0, 0, 0, 7, 0, 2'b01, 0, 0, 7, 0, 0, 0, 0);
    clr_a = 0;
    chk("clr_out", 64'(out_w[0]), 64'h0);
    chk("clr_vld", 64'(vld_w[0]), 64'h0);
    chk("clr_ovf", 64'(ovf_w[0]), 64'h0);
    chk("clr_stk", 64'(stk_w[0]), 64'h0);
    issue(0, 0, 0, 0, 7, 0, 2'b01, 0, 0, 14, 0, 0, 0, 0);
    va = 0;
    cyc();
    issue(0, 0, 0, 0, 7, 0, 2'b01, 0, 0, 21, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 7, 0, 2'b01, 0, 0, 28, 0, 0, 0, 0);
    idle(3);

    // Clock enable freeze mid-stream; clear and new inputs are ignored while frozen
    issue(0, 0, 0, 0, 1, 1000, 2'b00, 0, 0, 1001, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 2, 2000, 2'b00, 0, 0, 2002, 0, 0, 0, 0);
    ce = 0; clr_a = 1; va = 1;
    set_in(0, 0, 0, 9999, 9999, 2'b00, 0, 0);
    repeat (3) cyc();
    chk("freeze_out", 64'(out_w[0]), 64'd1001);
    chk("freeze_vld", 64'(vld_w[0]), 64'h1);
    ce = 1; clr_a = 0;
    issue(0, 0, 0, 0, 3, 3000, 2'b00, 0, 0, 3003, 0, 0, 0, 0);
    idle(3);

    // Asynchronous reset between edges while out=0x1234 with another item in flight
    set_in(0, 0, 0, 0, 48'h1234, 2'b00, 0, 0); va = 1; cyc();
    set_in(0, 0, 0, 0, 48'h10, 2'b00, 0, 0); cyc();
    va = 0;
    chk("pre_reset_out", 64'(out_w[0]), 64'h1234);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_out", 64'(out_w[0]), 64'h0);
    chk("async_rst_vld", 64'(vld_w[0]), 64'h0);
    chk("async_rst_flags", {61'h0, co_w[0], ovf_w[0], stk_w[0]}, 64'h0);
    cyc();
    rst_n = 1;
    issue(0, 0, 0, 0, 48'h11, 48'h55, 2'b00, 0, 0, 48'h66, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 1, 0, 2'b01, 0, 0, 48'h67, 0, 0, 0, 0);
    idle(3);

    // IN_REG=0 instance: one-cycle latency, accumulate and same-cycle clear
    issue(1, 0, 0, 0, 8, 50, 2'b00, 0, 0, 58, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 2, 0, 2'b01, 0, 0, 60, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 7, 7, 2'b00, 1, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 9, 9, 2'b00, 0, 0); vb = 1; clr_b = 1; cyc();
    vb = 0; clr_b = 0;
    chk("b_clr_out", 64'(out_w[1]), 64'h0);
    chk("b_clr_vld", 64'(vld_w[1]), 64'h0);
    idle(2);

    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) cyc();
    chk("drain_q0", 64'(q0.size()), 64'h0);
    chk("drain_q1", 64'(q1.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end
endmodule

// File: doc/pipe_add_sub_acc.md
Name: pipe_add_sub_acc

Overview:
- Parametrised, pipelined successor to the combinational pre-/post-adder helpers in the DSP slice.
- Pre-adder: PRE_WIDTH bits, d ± b.
- Post-adder: WIDTH bits, z ± x ± carryin. Its Z operand is selectable: external z, its own registered result (accumulate), or zero.
- Adds optional input registering, a global clock enable, valid tracking, synchronous accumulator clear, carry/borrow out, signed overflow and sticky overflow.
- Sits between the input operand registers and the P output of the DSP datapath.

Parameters:
- WIDTH, 48, post-adder/accumulator width.
- PRE_WIDTH, 18, pre-adder width.
- IN_REG, 1, 1 = register all inputs (stage 1); 0 = inputs feed the adders combinationally.

Ports:
- clk  in  1  clock, all registers rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable for every register in the block.
- in_valid  in  1  qualifies the current input set.
- d  in  PRE_WIDTH  pre-adder minuend/addend.
- b  in  PRE_WIDTH  pre-adder subtrahend/addend.
- pre_op  in  1  0 = d+b, 1 = d-b.
- x  in  WIDTH  post-adder operand.
- z  in  WIDTH  external post-adder base operand.
- zsel  in  2  00 = z, 01 = out (accumulate), 10 = zero, 11 = zero.
- post_op  in  1  0 = Z+x+carryin, 1 = Z-x-carryin.
- carryin  in  1  carry/borrow in.
- acc_clr  in  1  synchronous clear of the output stage.
- pre_out  out  PRE_WIDTH  registered pre-adder result.
- out  out  WIDTH  registered post-adder result (P).
- carryout  out  1  bit WIDTH of the unsigned WIDTH+1 result.
- overflow  out  1  signed overflow of the current result.
- ovf_sticky  out  1  OR of overflow since the last clear.
- out_valid  out  1  out/pre_out/flags are a fresh result.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage-1 registers, pre_out, out, carryout, overflow, ovf_sticky and out_valid go to 0 immediately. The block restarts clean on release, including mid-accumulation.
- ce=0: every register holds, including the valid pipeline and the sticky flag; acc_clr and in_valid are ignored.
- Stage 1 (IN_REG=1, ce=1): registers d, b, pre_op, x, z, zsel, post_op, carryin and in_valid each cycle, whatever in_valid is. With IN_REG=0 these signals pass straight through.
- Output stage, when ce=1, the stage-1 valid is 1 and acc_clr=0:
  - pre_out = (d ± b) mod 2^PRE_WIDTH.
  - Zop = z, out, or 0 according to zsel. For accumulate, Zop is the current out register value.
  - r = Zop + x + carryin (post_op=0) or Zop - x - carryin (post_op=1), computed unsigned at WIDTH+1 bits.
  - out = r[WIDTH-1:0]; carryout = r[WIDTH]. For subtract, carryout=1 means borrow.
  - overflow = 1 when the signed result of Zop ± x ± carryin, computed at WIDTH+2 bits, is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - ovf_sticky |= overflow.
  - out_valid = 1.
- Output stage, when ce=1 and the stage-1 valid is 0: pre_out, out, carryout, overflow and ovf_sticky hold; out_valid = 0. Bubbles do not disturb the accumulator.
- acc_clr (ce=1) acts on the output stage in the same cycle it is sampled; it is not pipelined:
  - out, carryout, overflow and ovf_sticky are cleared to 0; out_valid = 0; pre_out holds.
  - acc_clr has priority over a simultaneous valid result; that stage-1 item is dropped.
  - A stage-1 item behind it is processed normally on the next cycle.
- Latency from in_valid to out_valid = IN_REG + 1 cycles. Throughput is one result per cycle with ce=1.
- Back-to-back accumulate (zsel=01 on consecutive valid items) uses each previous result. There is no hazard because out updates every valid cycle.
- Wrap-around: out wraps modulo 2^WIDTH and pre_out modulo 2^PRE_WIDTH. There is no saturation; overflow/carryout report the condition.

Test Plan (WIDTH=48, PRE_WIDTH=18, IN_REG=1 unless stated):
- Reset mid-stream: assert rst_n=0 asynchronously between edges while out=0x1234 -> all outputs 0 before the next clk edge; first valid after release appears 2 cycles later.
- Basic add/sub: z=100, x=30, carryin=1, post_op=0 -> out=131, carryout=0, out_valid exactly 2 cycles after in_valid. Then post_op=1 -> out=69. Then z=5, x=10, carryin=0, post_op=1 -> out=2^48-5, carryout=1, overflow=0.
- Pre-adder: d=0x3FFFF, b=1, pre_op=0 -> pre_out=0. Then d=0, b=1, pre_op=1 -> pre_out=0x3FFFF.
- Accumulate: acc_clr, then x=7, zsel=01 for 4 consecutive valid cycles with an in_valid=0 bubble inserted between the 2nd and 3rd items -> out=7,14,(hold 14, out_valid=0),21,28.
- Overflow: z=0x7FFF_FFFF_FFFF, x=1, add -> out=0x8000_0000_0000, overflow=1, ovf_sticky=1. The next non-overflowing result gives overflow=0 and ovf_sticky still 1. acc_clr clears both, and a simultaneous valid item is dropped (out_valid=0).
- Clock enable and IN_REG=0: hold ce=0 for 3 cycles mid-stream -> outputs and out_valid frozen, then resume with no lost or duplicated results. With IN_REG=0, latency is 1 cycle.
